// File: rtl/crc_ahb_master.sv
// AHB-Lite master that programs a memory-mapped CRC unit: CR and INIT writes,
// a stream of DR data writes fed from a 2-entry input FIFO, then a DR read-back.
module crc_ahb_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic        start,
  input  logic [31:0] cfg_base,
  input  logic [7:0]  cfg_cr,
  input  logic [31:0] cfg_init,
  input  logic [7:0]  word_count,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] crc_result
);

  localparam logic [1:0]  HT_IDLE   = 2'b00;
  localparam logic [1:0]  HT_NONSEQ = 2'b10;
  localparam logic [31:0] OFS_CR    = 32'h0000_0008;
  localparam logic [31:0] OFS_INIT  = 32'h0000_0010;

  typedef enum logic [2:0] {
    IDLE, WR_CR, WR_INIT, WR_DATA, RD_RES, LAST_DP, ERR
  } state_t;

  state_t      state, state_d;
  logic [31:0] base_q, init_q;
  logic [7:0]  cr_q, wc_q, rem_q;
  logic [31:0] fifo_mem [2];
  logic        wptr, rptr;
  logic [1:0]  cnt, cnt_d;
  logic        dr_req, dp_valid;
  logic        err_hit, nonseq, addr_done, push, pop, flush, rd_done;

  assign HSIZE     = 3'b010;
  assign din_ready = (cnt != 2'd2);
  assign push      = din_valid & din_ready;
  assign err_hit   = dp_valid & HRESP;
  assign nonseq    = (HTRANS == HT_NONSEQ);
  assign addr_done = HREADY & nonseq & ~err_hit;
  assign pop       = addr_done & (state == WR_DATA);
  assign flush     = (state == ERR) & HREADY;
  assign rd_done   = (state == LAST_DP) & HREADY & ~err_hit;
  assign cnt_d     = cnt + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_d;
  end

  // An error response in any data phase overrides the normal sequence.
  always_comb begin
    state_d = state;
    if (err_hit && state != IDLE && state != ERR) begin
      state_d = ERR;
    end else begin
      case (state)
        IDLE:    if (start)  state_d = WR_CR;
        WR_CR:   if (HREADY) state_d = WR_INIT;
        WR_INIT: if (HREADY) state_d = (wc_q == 8'd0) ? RD_RES : WR_DATA;
        WR_DATA: if (addr_done && rem_q == 8'd1) state_d = RD_RES;
        RD_RES:  if (HREADY) state_d = LAST_DP;
        LAST_DP: if (HREADY) state_d = IDLE;
        ERR:     if (HREADY) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    HTRANS = HT_IDLE;
    HADDR  = 32'h0;
    HWRITE = 1'b0;
    busy   = (state != IDLE);
    case (state)
      WR_CR: begin
        HTRANS = HT_NONSEQ;
        HADDR  = base_q + OFS_CR;
        HWRITE = 1'b1;
      end
      WR_INIT: begin
        HTRANS = HT_NONSEQ;
        HADDR  = base_q + OFS_INIT;
        HWRITE = 1'b1;
      end
      WR_DATA: begin
        HTRANS = dr_req ? HT_NONSEQ : HT_IDLE;
        HADDR  = base_q;
        HWRITE = 1'b1;
      end
      RD_RES: begin
        HTRANS = HT_NONSEQ;
        HADDR  = base_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      base_q <= 32'h0;
      init_q <= 32'h0;
      cr_q   <= 8'h0;
      wc_q   <= 8'h0;
      rem_q  <= 8'h0;
    end else if (state == IDLE && start) begin
      base_q <= cfg_base;
      init_q <= cfg_init;
      cr_q   <= cfg_cr;
      wc_q   <= word_count;
      rem_q  <= word_count;
    end else if (pop) begin
      rem_q <= rem_q - 8'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fifo_mem[0] <= 32'h0;
      fifo_mem[1] <= 32'h0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      cnt         <= 2'd0;
    end else if (flush) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wptr] <= din;
        wptr           <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt_d;
    end
  end

  // Address-phase qualifiers only move on HREADY so wait states freeze the bus.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dr_req   <= 1'b0;
      dp_valid <= 1'b0;
    end else if (HREADY) begin
      dr_req   <= (state_d == WR_DATA) && (cnt_d != 2'd0);
      dp_valid <= addr_done;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HWDATA <= 32'h0;
    end else if (addr_done) begin
      case (state)
        WR_CR:   HWDATA <= {24'h0, cr_q};
        WR_INIT: HWDATA <= init_q;
        WR_DATA: HWDATA <= fifo_mem[rptr];
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      crc_result <= 32'h0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (rd_done) crc_result <= HRDATA;
      done  <= rd_done | flush;
      error <= flush;
    end
  end

endmodule
